serial_sub8: RTL and testbench



---
 rtl/serial_sub8_pkg.sv | 14 +
 rtl/serial_sub8_full_subtractor.sv | 17 +
 rtl/serial_sub8.sv | 109 ++++++++++
 tb/tb_serial_sub8.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub8_pkg.sv
// Shared arithmetic definitions for the bit-serial subtractor.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   SUB_WIDTH : default operand/result width
package serial_sub8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH = 8;

endpackage

// File: rtl/serial_sub8_full_subtractor.sv
// One-bit full subtractor cell, mirror of the full-adder cell.
//   a, b   : minuend / subtrahend bits
//   b_in   : borrow in
//   d      : difference bit, a ^ b ^ b_in
//   b_out  : borrow out, set when a < b + b_in
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial LSB-first subtractor: d = a - b - b_in over WIDTH cycles.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   start    : request, accepted only while busy = 0
//   a, b     : operands, captured on the accepting edge
//   b_in     : borrow in, captured on the accepting edge
//   busy     : serial computation in progress
//   valid    : d / b_out / v_out hold a completed result
//   d        : difference modulo 2^WIDTH
//   b_out    : unsigned borrow out
//   v_out    : signed two's-complement overflow
module serial_sub8
    import serial_sub8_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             v_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_bit;
    logic               diff_bit;
    logic               br_next;

    // Only the latched operand copies are used, so inputs may change while busy.
    assign accept   = (state_q != RUN) && start;
    assign last_bit = (state_q == RUN) && (cnt == CNT_W'(WIDTH - 1));

    full_subtractor u_fs (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .b_in  (br),
        .d     (diff_bit),
        .b_out (br_next)
    );

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)    state_d = RUN;
            RUN:        if (last_bit) state_d = DONE;
            default:                  state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == RUN);
    assign valid = (state_q == DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the shift registers are reset too; they are small and it keeps d free of stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            b_out  <= 1'b0;
            v_out  <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            br   <= b_in;
            cnt  <= '0;
        end else if (state_q == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {diff_bit, res_sr[WIDTH-1:1]};
            br     <= br_next;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                // On the last step a_sr[0]/b_sr[0] are the latched operand MSBs
                // and diff_bit is the result MSB.
                d     <= {diff_bit, res_sr[WIDTH-1:1]};
                b_out <= br_next;
                v_out <= (a_sr[0] ^ b_sr[0]) & (diff_bit ^ a_sr[0]);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: a driver issues directed and random
// operations and queues the expected result; a monitor pops and compares each
// time valid rises, and also checks busy length, valid-during-run and hold.
module tb_serial_sub8;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         b_out;
        logic         v_out;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         valid;
    logic [W-1:0] d;
    logic         b_out;
    logic         v_out;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    serial_sub8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .valid (valid),
        .d     (d),
        .b_out (b_out),
        .v_out (v_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide unsigned arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t       e;
        logic [W:0] full;
        full    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.d     = full[W-1:0];
        e.b_out = full[W];
        e.v_out = (ma[W-1] != mb[W-1]) && (e.d[W-1] != ma[W-1]);
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic         prev_busy  = 1'b0;
    logic         prev_valid = 1'b0;
    int           run_len    = 0;
    logic [W-1:0] held_d;

    always @(negedge clk) begin
        if (rst) begin
            prev_busy  = 1'b0;
            prev_valid = 1'b0;
            run_len    = 0;
        end else begin
            if (busy) begin
                run_len++;
                check("valid_low_in_run", {31'd0, valid}, 32'd0);
            end
            if (prev_busy && !busy) begin
                check("busy_length", run_len, W);
                run_len = 0;
            end
            if (valid && !prev_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_valid: got valid=1 expected no result pending");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("d",     {24'd0, d},      {24'd0, e.d});
                    check("b_out", {31'd0, b_out},  {31'd0, e.b_out});
                    check("v_out", {31'd0, v_out},  {31'd0, e.v_out});
                end
                held_d = d;
            end else if (valid && prev_valid) begin
                check("d_held", {24'd0, d}, {24'd0, held_d});
            end
            prev_busy  = busy;
            prev_valid = valid;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 100 cycles");
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        wait_idle();
        a     = ia;
        b     = ib;
        b_in  = ibin;
        start = 1'b1;
        q.push_back(model(ia, ib, ibin));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        check(name, {27'd0, busy, valid, b_out, v_out, |d}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        b_in  = 1'b0;
        #1;
        check_zero_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        issue(8'h05, 8'h03, 1'b0);
        issue(8'h00, 8'h01, 1'b0);
        issue(8'h80, 8'h01, 1'b0);
        issue(8'h7F, 8'hFF, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1);
        issue(8'h10, 8'h00, 1'b1);
        issue(8'h00, 8'hFF, 1'b1);

        // Start while busy is ignored; operands change mid-run.
        issue(8'h20, 8'h10, 1'b0);
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        b_in  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Start held high: back-to-back operations with fresh operands each cycle.
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            b_in  = 1'($urandom);
            start = 1'b1;
            if (!busy) q.push_back(model(a, b, b_in));
            @(negedge clk);
        end
        start = 1'b0;

        // Reset in the middle of a run.
        issue(8'h55, 8'h22, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check_zero_outputs("reset_mid_run");
        @(negedge clk);
        #2;
        rst = 1'b0;
        issue(8'h55, 8'h22, 1'b0);

        // Random operations with random idle gaps.
        for (int i = 0; i < 150; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
